// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with a one-entry multicycle-op scoreboard.
// Optional performance counters are compiled in when PIPE_PERF_EN is defined.
module pipeline_ctrl #(
    parameter int unsigned REGW = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lwstall,
    input  logic [REGW-1:0] rs0D,
    input  logic [REGW-1:0] rs1D,
    input  logic            branch_takenE,
    input  logic            mc_startE,
    input  logic [REGW-1:0] mc_rdE,
    input  logic            mc_done,
    input  logic            mem_busy,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            stallM,
    output logic            flushD,
    output logic            flushE,
    output logic            mc_pending,
    output logic            mc_issue
`ifdef PIPE_PERF_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_flush_count,
    output logic [31:0]     perf_mc_wait
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MC_FULL  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [REGW-1:0] pend_rd;
    logic [REGW-1:0] pend_rd_nx;
    logic            pending_nx;
    logic            sb_hit;
    logic            mc_free;
    logic            run_eval;
    logic            branch_flush;

    // Register 0 is hard-wired, so a pending write to it never creates a hazard.
    assign sb_hit = mc_pending & ~mc_done & (pend_rd != '0)
                  & ((rs0D == pend_rd) | (rs1D == pend_rd));
    assign mc_free = ~mc_pending | mc_done;

    // Next-state, scoreboard update and combinational stall/flush outputs.
    always_comb begin
        state_nx     = state;
        pend_rd_nx   = pend_rd;
        pending_nx   = mc_pending;
        stallF       = 1'b0;
        stallD       = 1'b0;
        stallE       = 1'b0;
        stallM       = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;
        mc_issue     = 1'b0;
        run_eval     = 1'b0;
        branch_flush = 1'b0;

        case (state)
            ST_RUN: begin
                run_eval = 1'b1;
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    stallF   = 1'b1;
                    stallD   = 1'b1;
                    stallE   = 1'b1;
                    stallM   = 1'b1;
                    state_nx = ST_MEM_WAIT;
                end else begin
                    run_eval = 1'b1;
                end
            end
            ST_MC_FULL: begin
                if (mem_busy) begin
                    stallF   = 1'b1;
                    stallD   = 1'b1;
                    stallE   = 1'b1;
                    stallM   = 1'b1;
                    state_nx = ST_MEM_WAIT;
                end else if (mc_done) begin
                    mc_issue = 1'b1;
                    state_nx = ST_RUN;
                end else begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                end
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase

        // Normal evaluation; a blocked multicycle issue freezes E and bubbles M.
        if (run_eval) begin
            state_nx = ST_RUN;
            if (mem_busy) begin
                stallF   = 1'b1;
                stallD   = 1'b1;
                stallE   = 1'b1;
                stallM   = 1'b1;
                state_nx = ST_MEM_WAIT;
            end else if (mc_startE && !mc_free) begin
                stallF   = 1'b1;
                stallD   = 1'b1;
                stallE   = 1'b1;
                state_nx = ST_MC_FULL;
            end else begin
                if (branch_takenE) begin
                    flushD       = 1'b1;
                    flushE       = 1'b1;
                    branch_flush = 1'b1;
                end else if (lwstall || sb_hit) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
                mc_issue = mc_startE;
            end
        end

        if (mc_issue) begin
            pend_rd_nx = mc_rdE;
            pending_nx = 1'b1;
        end else if (mc_done) begin
            pending_nx = 1'b0;
        end

        if (rst) begin
            stallF       = 1'b0;
            stallD       = 1'b0;
            stallE       = 1'b0;
            stallM       = 1'b0;
            flushD       = 1'b1;
            flushE       = 1'b1;
            mc_issue     = 1'b0;
            branch_flush = 1'b0;
        end
    end

    // State and scoreboard registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            mc_pending <= 1'b0;
            pend_rd    <= '0;
        end else begin
            state      <= state_nx;
            mc_pending <= pending_nx;
            pend_rd    <= pend_rd_nx;
        end
    end

`ifdef PIPE_PERF_EN
    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= 32'd0;
            perf_flush_count  <= 32'd0;
            perf_mc_wait      <= 32'd0;
        end else begin
            if (stallF)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (branch_flush)
                perf_flush_count <= perf_flush_count + 32'd1;
            if (sb_hit || (state == ST_MC_FULL))
                perf_mc_wait <= perf_mc_wait + 32'd1;
        end
    end
`endif

endmodule
